// File: rtl/base_aburp_rrarb.sv
// Packet-aware round-robin arbiter: `ways` valid/ready requesters share one output
// channel through a 2-entry skid stage, so every i_r bit comes straight from a flop.
module base_aburp_rrarb #(
   parameter int ways  = 4,
   parameter int width = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [0:ways-1]       i_v,
   output logic [0:ways-1]       i_r,
   input  logic [0:ways-1]       i_e,
   input  logic [0:ways*width-1] i_d,
   output logic                  o_v,
   input  logic                  o_r,
   output logic [0:width-1]      o_d,
   output logic                  o_e,
   output logic [0:ways-1]       o_s
);

   localparam int iw = (ways > 1) ? $clog2(ways) : 1;
   localparam logic [iw-1:0] last_idx = iw'(ways - 1);

   // Handshake: a beat moves on requester k when i_v[k] & i_r[k] at a rising clk
   // edge, and on the output when o_v & o_r. A source holds valid and payload
   // stable until its beat moves; valid never waits on ready.

   logic                 lock, lock_nxt;
   logic [iw-1:0]        lock_idx, lock_idx_nxt;
   logic [iw-1:0]        ptr, ptr_nxt;
   logic [iw-1:0]        gnt_idx, gnt_nxt;
   logic [iw-1:0]        cand;
   logic                 found;
   logic [0:ways-1]      ir_q, ir_nxt;
   logic [1:0]           count, count_nxt;

   logic [0:width-1]     hd_d, hd_d_nxt, tl_d, tl_d_nxt;
   logic                 hd_e, hd_e_nxt, tl_e, tl_e_nxt;
   logic [0:ways-1]      hd_s, hd_s_nxt, tl_s, tl_s_nxt;

   logic                 acc, drn;
   logic [0:width-1]     acc_d;
   logic                 acc_e;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock     <= 1'b0;
         lock_idx <= '0;
         ptr      <= last_idx;
         gnt_idx  <= '0;
         ir_q     <= '0;
         count    <= 2'd0;
         hd_d     <= '0;
         hd_e     <= 1'b0;
         hd_s     <= '0;
         tl_d     <= '0;
         tl_e     <= 1'b0;
         tl_s     <= '0;
      end else begin
         lock     <= lock_nxt;
         lock_idx <= lock_idx_nxt;
         ptr      <= ptr_nxt;
         gnt_idx  <= gnt_nxt;
         ir_q     <= ir_nxt;
         count    <= count_nxt;
         hd_d     <= hd_d_nxt;
         hd_e     <= hd_e_nxt;
         hd_s     <= hd_s_nxt;
         tl_d     <= tl_d_nxt;
         tl_e     <= tl_e_nxt;
         tl_s     <= tl_s_nxt;
      end
   end

   // ------------------------------------------------------- accept decode
   // ir_q is one-hot or zero, so at most one requester can match here.
   always_comb begin
      acc   = 1'b0;
      acc_d = '0;
      acc_e = 1'b0;
      for (int k = 0; k < ways; k++) begin
         if (ir_q[k] && i_v[k]) begin
            acc   = 1'b1;
            acc_d = i_d[k*width +: width];
            acc_e = i_e[k];
         end
      end
      drn = (count != 2'd0) && o_r;
   end

   // ------------------------------------------------ lock / pointer / grant
   always_comb begin
      lock_nxt     = lock;
      lock_idx_nxt = lock_idx;
      ptr_nxt      = ptr;
      if (acc) begin
         if (acc_e) begin
            lock_nxt = 1'b0;
            ptr_nxt  = gnt_idx;
         end else begin
            lock_nxt     = 1'b1;
            lock_idx_nxt = gnt_idx;
         end
      end

      // A locked packet keeps the grant even while its source idles.
      gnt_nxt = lock_idx_nxt;
      found   = 1'b0;
      cand    = '0;
      if (lock_nxt) begin
         found = |i_v;
      end else begin
         for (int off = 1; off <= ways; off++) begin
            cand = iw'((int'(ptr_nxt) + off) % ways);
            if (!found && i_v[cand]) begin
               found   = 1'b1;
               gnt_nxt = cand;
            end
         end
      end
   end

   // ----------------------------------------------------------- skid stage
   always_comb begin
      count_nxt = count;
      hd_d_nxt  = hd_d;
      hd_e_nxt  = hd_e;
      hd_s_nxt  = hd_s;
      tl_d_nxt  = tl_d;
      tl_e_nxt  = tl_e;
      tl_s_nxt  = tl_s;
      case ({acc, drn})
         2'b10: begin
            if (count == 2'd0) begin
               hd_d_nxt = acc_d;
               hd_e_nxt = acc_e;
               hd_s_nxt = ir_q;
            end else begin
               tl_d_nxt = acc_d;
               tl_e_nxt = acc_e;
               tl_s_nxt = ir_q;
            end
            count_nxt = count + 2'd1;
         end
         2'b01: begin
            if (count == 2'd2) begin
               hd_d_nxt = tl_d;
               hd_e_nxt = tl_e;
               hd_s_nxt = tl_s;
            end
            count_nxt = count - 2'd1;
         end
         2'b11: begin
            if (count == 2'd1) begin
               hd_d_nxt = acc_d;
               hd_e_nxt = acc_e;
               hd_s_nxt = ir_q;
            end else begin
               hd_d_nxt = tl_d;
               hd_e_nxt = tl_e;
               hd_s_nxt = tl_s;
               tl_d_nxt = acc_d;
               tl_e_nxt = acc_e;
               tl_s_nxt = ir_q;
            end
         end
         default: ;
      endcase

      // Ready is offered only if the stage will still have room next cycle.
      ir_nxt = '0;
      if (found && (count_nxt < 2'd2)) ir_nxt[gnt_nxt] = 1'b1;
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      i_r = ir_q;
      o_v = (count != 2'd0);
      o_d = hd_d;
      o_e = hd_e;
      o_s = hd_s;
   end

   a_count_max: assert property (@(posedge clk) disable iff (reset) count <= 2'd2);
   a_ir_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(ir_q));
   a_no_ovf:    assert property (@(posedge clk) disable iff (reset) !(acc && count == 2'd2));
   a_out_hold:  assert property (@(posedge clk) disable iff (reset)
                   (o_v && !o_r) |=> ($stable(o_d) && $stable(o_e) && $stable(o_s)));

endmodule

// File: tb/tb_base_aburp_rrarb.sv
// Bench for base_aburp_rrarb: per-requester source queues drive the inputs,
// expected beats are queued in hand-computed order and checked by a monitor.
module tb_base_aburp_rrarb;

   localparam int ways  = 4;
   localparam int width = 8;
   localparam int W     = 11;   // {src[1:0], eop, data[7:0]}

   logic                  clk;
   logic                  reset;
   logic [0:ways-1]       i_v;
   logic [0:ways-1]       i_r;
   logic [0:ways-1]       i_e;
   logic [0:ways*width-1] i_d;
   logic                  o_v;
   logic                  o_r;
   logic [0:width-1]      o_d;
   logic                  o_e;
   logic [0:ways-1]       o_s;

   logic [W-1:0]    exp_q[$];
   logic [8:0]      src_q [ways][$];
   logic [0:ways-1] pause;
   int              total;
   int              bad;

   base_aburp_rrarb #(.ways(ways), .width(width)) dut (
      .clk   (clk),
      .reset (reset),
      .i_v   (i_v),
      .i_r   (i_r),
      .i_e   (i_e),
      .i_d   (i_d),
      .o_v   (o_v),
      .o_r   (o_r),
      .o_d   (o_d),
      .o_e   (o_e),
      .o_s   (o_s)
   );

   // ------------------------------------------------------ clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ------------------------------------------------------------ helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic src(input int k, input logic e, input logic [7:0] d);
      src_q[k].push_back({e, d});
   endtask

   task automatic expect_beat(input int k, input logic e, input logic [7:0] d);
      exp_q.push_back({2'(k), e, d});
   endtask

   function automatic bit srcs_empty();
      for (int k = 0; k < ways; k++) if (src_q[k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic wait_ov(input string name);
      for (int i = 0; i < 30 && !o_v; i++) tick();
      total++;
      if (!o_v) begin
         bad++;
         $display("FAIL %s_wait_ov: got o_v=0 want o_v=1 within 30 cycles", name);
      end
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 200 && !(srcs_empty() && exp_q.size() == 0 && !o_v); i++) tick();
      total++;
      if (!(srcs_empty() && exp_q.size() == 0 && !o_v)) begin
         bad++;
         $display("FAIL %s_drain: got %0d beats pending want 0 within 200 cycles",
                  name, exp_q.size());
      end
   endtask

   // ------------------------------------------------------------- driver
   initial begin
      logic [0:ways-1] xfer;
      logic [8:0]      cur;
      i_v = '0;
      i_e = '0;
      i_d = '0;
      forever begin
         @(negedge clk);
         xfer = i_v & i_r;
         @(posedge clk);
         #1;
         for (int k = 0; k < ways; k++) begin
            if (xfer[k] && !reset && src_q[k].size() != 0) cur = src_q[k].pop_front();
            if (!pause[k] && src_q[k].size() != 0) begin
               cur                   = src_q[k][0];
               i_v[k]                = 1'b1;
               i_e[k]                = cur[8];
               i_d[k*width +: width] = cur[7:0];
            end else begin
               i_v[k] = 1'b0;
               i_e[k] = 1'b0;
            end
         end
      end
   end

   // -------------------------------------------------- scoreboard monitor
   initial begin
      logic [W-1:0]     e;
      logic [0:ways-1]  oh;
      logic             stall_prev;
      logic [0:width-1] d_prev;
      logic             e_prev;
      logic [0:ways-1]  s_prev;
      stall_prev = 1'b0;
      d_prev     = '0;
      e_prev     = 1'b0;
      s_prev     = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev && o_v) begin
               chk("hold_d", 32'(o_d), 32'(d_prev));
               chk("hold_e", 32'(o_e), 32'(e_prev));
               chk("hold_s", 32'(o_s), 32'(s_prev));
            end
            if (o_v && o_r) begin
               if (exp_q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL extra_beat: got d=0x%0h s=%b want no beat", o_d, o_s);
               end else begin
                  e  = exp_q.pop_front();
                  oh = '0;
                  oh[e[10:9]] = 1'b1;
                  chk("out_d", 32'(o_d), 32'(e[7:0]));
                  chk("out_e", 32'(o_e), 32'(e[8]));
                  chk("out_s", 32'(o_s), 32'(oh));
               end
            end
            stall_prev = o_v && !o_r;
            d_prev     = o_d;
            e_prev     = o_e;
            s_prev     = o_s;
         end
      end
   end

   // ------------------------------------------------------- directed tests
   initial begin
      total = 0;
      bad   = 0;
      pause = '0;
      o_r   = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #2;
      chk("rst_o_v", 32'(o_v), 32'(0));
      chk("rst_i_r", 32'(i_r), 32'(0));
      chk("rst_o_s", 32'(o_s), 32'(0));
      chk("rst_o_d", 32'(o_d), 32'(0));
      chk("rst_o_e", 32'(o_e), 32'(0));
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("idle_i_r", 32'(i_r), 32'(0));

      // 1: all four requesters, single-beat packets, full rate rotation
      o_r = 1'b1;
      for (int k = 0; k < ways; k++) begin
         src(k, 1'b1, 8'(8'h10 + k));
         src(k, 1'b1, 8'(8'h20 + k));
      end
      for (int k = 0; k < ways; k++) expect_beat(k, 1'b1, 8'(8'h10 + k));
      for (int k = 0; k < ways; k++) expect_beat(k, 1'b1, 8'(8'h20 + k));
      wait_ov("t1");
      for (int i = 0; i < 8; i++) begin
         chk("t1_rate", 32'(o_v), 32'(1));
         tick();
      end
      wait_drain("t1");

      // 2: 3-beat packet on 2 holds the grant; pointer moves to 2 so 3 beats 0
      src(2, 1'b0, 8'hA0);
      src(2, 1'b0, 8'hA1);
      src(2, 1'b1, 8'hA2);
      tick();
      src(0, 1'b1, 8'hB0);
      src(0, 1'b1, 8'hB1);
      src(3, 1'b1, 8'hC0);
      expect_beat(2, 1'b0, 8'hA0);
      expect_beat(2, 1'b0, 8'hA1);
      expect_beat(2, 1'b1, 8'hA2);
      expect_beat(3, 1'b1, 8'hC0);
      expect_beat(0, 1'b1, 8'hB0);
      expect_beat(0, 1'b1, 8'hB1);
      wait_drain("t2");

      // 3: output stall fills the skid stage, ready closes, data holds
      o_r = 1'b0;
      for (int i = 0; i < 5; i++) begin
         src(1, 1'b1, 8'(8'h50 + i));
         expect_beat(1, 1'b1, 8'(8'h50 + i));
      end
      wait_ov("t3");
      chk("t3_ir_open", 32'(i_r), 32'(4'b0100));
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("t3_ir_closed", 32'(i_r), 32'(0));
         chk("t3_hold_v", 32'(o_v), 32'(1));
         chk("t3_head_d", 32'(o_d), 32'(8'h50));
         tick();
      end
      o_r = 1'b1;
      wait_drain("t3");

      // 4: locked requester 1 idles mid-packet; requester 3 must wait
      src(1, 1'b0, 8'h60);
      src(1, 1'b0, 8'h61);
      src(1, 1'b1, 8'h62);
      expect_beat(1, 1'b0, 8'h60);
      expect_beat(1, 1'b0, 8'h61);
      expect_beat(1, 1'b1, 8'h62);
      expect_beat(3, 1'b1, 8'h70);
      for (int i = 0; i < 30 && src_q[1].size() > 2; i++) tick();
      chk("t4_first_beat", 32'(src_q[1].size() <= 2), 32'(1));
      pause[1] = 1'b1;
      src(3, 1'b1, 8'h70);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("t4_no_grant3", 32'(i_r[3]), 32'(0));
      end
      pause[1] = 1'b0;
      wait_drain("t4");

      // 5: async reset with a full skid stage; pointer returns to requester 0 first
      src(1, 1'b1, 8'h80);
      expect_beat(1, 1'b1, 8'h80);
      wait_drain("t5a");
      o_r = 1'b0;
      for (int i = 0; i < 4; i++) src(0, (i == 3), 8'(8'h90 + i));
      for (int i = 0; i < 4; i++) expect_beat(0, (i == 3), 8'(8'h90 + i));
      wait_ov("t5");
      tick();
      chk("t5_full_v", 32'(o_v), 32'(1));
      chk("t5_full_ir", 32'(i_r), 32'(0));
      chk("t5_full_s", 32'(o_s), 32'(4'b1000));
      #1 reset = 1'b1;
      #1;
      chk("t5_async_o_v", 32'(o_v), 32'(0));
      chk("t5_async_i_r", 32'(i_r), 32'(0));
      chk("t5_async_o_s", 32'(o_s), 32'(0));
      exp_q.delete();
      for (int k = 0; k < ways; k++) src_q[k].delete();
      tick();
      tick();
      reset = 1'b0;
      o_r   = 1'b1;
      for (int k = 0; k < ways; k++) begin
         src(k, 1'b1, 8'(8'hC0 + k));
         expect_beat(k, 1'b1, 8'(8'hC0 + k));
      end
      wait_drain("t5b");

      // 6: only the last requester, back-to-back single beats at full rate
      for (int i = 0; i < 6; i++) begin
         src(3, 1'b1, 8'(8'hE0 + i));
         expect_beat(3, 1'b1, 8'(8'hE0 + i));
      end
      wait_ov("t6");
      for (int i = 0; i < 6; i++) begin
         chk("t6_rate", 32'(o_v), 32'(1));
         chk("t6_ir", 32'(i_r), 32'(4'b0001));
         tick();
      end
      wait_drain("t6");

      chk("sb_empty", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/base_aburp_rrarb.md
Name: base_aburp_rrarb

Overview:
- N-way round-robin arbiter sharing one valid/ready (burp-style) output channel among `ways` requesters.
- Packet-aware: once a requester's first beat is accepted, the grant is held until its end-of-packet beat is accepted.
- Output goes through an internal 2-entry skid stage, so every i_r is registered and has no combinational path from o_r.
- Sits in front of a shared downstream pipeline stage or resource port.

Parameters:
- ways, 4, number of requesters (>=2).
- width, 8, data bits per beat.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- i_v  input  [0:ways-1]  per-requester valid.
- i_r  output  [0:ways-1]  per-requester ready; registered.
- i_e  input  [0:ways-1]  per-requester end-of-packet flag, qualified by i_v.
- i_d  input  [0:ways*width-1]  requester k data at bits [k*width : k*width+width-1].
- o_v  output  1  output valid.
- o_r  input  1  output ready.
- o_d  output  [0:width-1]  output data.
- o_e  output  1  end-of-packet flag travelling with o_d.
- o_s  output  [0:ways-1]  one-hot source of the current output beat.

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous and active-high; all flops clear on reset assertion without waiting for clk.
- Reset values: o_v=0, i_r=all 0, lock=0, skid count=0, rr pointer=ways-1 (requester 0 has first priority), o_d/o_e/o_s=0.
- Transfers: an input transfer on k occurs when i_v[k]&i_r[k]; an output transfer occurs when o_v&o_r.
- Grant, unlocked: grant goes to the first k with i_v[k]=1, searching pointer+1, pointer+2, ... modulo ways.
- Grant, locked: grant stays on the locked index regardless of i_v.
  - A locked requester that drops i_v mid-packet stalls the channel; there is no switch-away.
- i_r[k] is registered: i_r[k] = grant[k] & (count<2), computed for the next cycle.
  - At most one i_r bit is set per cycle.
  - No i_r bit is set while no requester has i_v.
- Lock:
  - Set on an accepted beat with i_e=0.
  - Cleared on an accepted beat with i_e=1.
  - A single-beat packet (i_e=1 on the first beat) never sets lock.
- Pointer:
  - Loads the granted index on every accepted i_e=1 beat.
  - Otherwise holds.
- Skid stage:
  - count in 0..2.
  - Accept only: +1. Drain only: -1. Simultaneous accept and drain: count unchanged, order preserved (FIFO).
  - count=2 blocks acceptance. count=0 forces o_v=0.
  - count never exceeds 2; this is an assertion.
- Latency: a beat accepted in cycle t appears on o_v/o_d/o_e/o_s in cycle t+1 when the stage was empty.
- Throughput: 1 beat/cycle sustained when o_r is held at 1.
- Output stability: while o_v=1 and o_r=0, o_d, o_e and o_s hold stable.
- i_r timing: because i_r is registered, a beat may be presented with i_r=0. The requester holds i_v and i_d until accepted, per the codebase handshake rules.
- Switchover: a new grant computed at packet end takes effect on i_r in the cycle after the i_e=1 beat is accepted. No beat is lost or duplicated.
- Reset mid-packet: lock, pointer and skid contents are discarded. Beats held in the skid stage are dropped.

Test Plan:
- Reset, then i_v=4'b1111 with all single-beat packets (i_e=1) and o_r=1 -> o_s sequence 0,1,2,3,0,... one beat per cycle after the first.
- i_v[2]=1, 3-beat packet D0..D2 (i_e on D2) while i_v[0]=1 from cycle 1 -> o_s=2 for D0,D1,D2 contiguously, then o_s=0. Pointer=2 after D2.
- Full stream with o_r=0 for 3 cycles -> count reaches 2, i_r goes 0 the next cycle, o_d held stable. On o_r=1, data drains in order with no loss or duplicate.
- Locked requester 1 drops i_v for 2 cycles mid-packet while i_v[3]=1 -> no grant to 3 until requester 1 resumes and its i_e beat is accepted.
- Assert reset asynchronously mid-packet with count=2 -> o_v, i_r and o_s drop immediately without a clk edge. After release, requester 0 is served first.
- Only requester ways-1 active, continuous single-beat packets -> pointer wraps and the requester is re-granted every cycle at full rate.
